// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small synchronous FIFO.
// Frame = start bit, DATA_BITS data bits (LSB first), optional parity bit,
// STOP_BITS stop bits; each bit is held for CLKS_PER_BIT clk cycles.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data
// bits (even parity when par_odd=0, odd parity when par_odd=1).
// Reset is synchronous and active-low.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        par_odd,
  output logic                        tx,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  // Fullness alone decides acceptance; a pop on the same edge does not help.
  assign in_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready && rst_n;
  assign head     = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the data array has no reset; pointers and level define validity,
  // so clearing the storage itself would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because depth is 2^n.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t               state,    state_n;
  logic [BAUD_W-1:0]    baud_cnt, baud_n;
  logic [BIT_W-1:0]     bit_cnt,  bit_n;
  logic [DATA_BITS-1:0] shift,    shift_n;
  logic                 tx_q,     tx_n;
  logic                 done_q,   done_n;
  logic                 bit_end;
  logic                 next_frame;

`ifdef UART_TX_PARITY_EN
  logic                 par_bit,  par_n;
`else
  logic                 unused_par_odd;
  assign unused_par_odd = par_odd;
`endif

  assign bit_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx      = tx_q;
  assign done    = done_q;
  assign busy    = (state != IDLE);

  // State register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_n;
`endif
    end
  end

  // Next-state, next-output and FIFO pop decision.
  // NOTE: every signal gets a default at the top of the block so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    baud_n     = baud_cnt + BAUD_W'(1);
    bit_n      = bit_cnt;
    shift_n    = shift;
    tx_n       = tx_q;
    done_n     = 1'b0;
    pop        = 1'b0;
    next_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par_bit;
`endif

    case (state)
      IDLE: begin
        baud_n     = '0;
        bit_n      = '0;
        tx_n       = 1'b1;
        next_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_n   = '0;
`ifdef UART_TX_PARITY_EN
            tx_n    = par_bit;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
            tx_n  = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            done_n     = 1'b1;
            bit_n      = '0;
            tx_n       = 1'b1;
            state_n    = IDLE;
            next_frame = 1'b1;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Launch the next frame straight from IDLE or from the final stop edge,
    // so queued words leave with no idle gap between frames.
    if (next_frame && (fifo_level != '0)) begin
      pop     = 1'b1;
      shift_n = head;
      tx_n    = 1'b0;
      baud_n  = '0;
      bit_n   = '0;
      state_n = START;
`ifdef UART_TX_PARITY_EN
      par_n   = (^head) ^ par_odd;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// Two instances at CLKS_PER_BIT=4: one with one stop bit, one with two.
// Follows UART_TX_PARITY_EN if the macro is defined at compile time.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB  = 1 + 8 + PAR + 1;  // bits per frame, one stop bit
  localparam int FL  = NB * CPB;         // cycles per frame
  localparam int NB2 = NB + 1;           // bits per frame, two stop bits

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       par_odd;
  logic       tx;
  logic       busy;
  logic       done;
  logic [2:0] fifo_level;

  logic [7:0] in_data2;
  logic       in_valid2;
  logic       in_ready2;
  logic       tx2;
  logic       busy2;
  logic       done2;
  logic [2:0] fifo_level2;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .par_odd(par_odd), .tx(tx), .busy(busy),
    .done(done), .fifo_level(fifo_level)
  );

  uart_tx_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .par_odd(par_odd), .tx(tx2), .busy(busy2),
    .done(done2), .fifo_level(fifo_level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit slot idx of a frame carrying d with parity p.
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR == 1 && idx == 9) return p;
    return 1'b1;
  endfunction

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;   // must be ignored while in reset
    in_data  = 8'h55;
    step();
    step();
    total++;
    if ({tx, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_outputs: tx/busy/done got %b want 100", {tx, busy, done});
    end
    total++;
    if (fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL reset_level: got %0d want 0", fifo_level);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    total++;
    if ({tx2, busy2, done2, in_ready2, fifo_level2} !== 7'b1001_000) begin
      bad++;
      $display("FAIL reset_dut2: got %b want 1001000",
               {tx2, busy2, done2, in_ready2, fifo_level2});
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    total++;
    if ({tx, busy, fifo_level} !== 5'b10_000) begin
      bad++;
      $display("FAIL reset_idle: tx/busy/level got %b want 10000", {tx, busy, fifo_level});
    end
  endtask

  // One isolated frame; d and pod change right after they are sampled.
  task automatic test_single_frame(input string name, input logic [7:0] d,
                                   input logic pod, input logic pexp);
    in_data  = d;
    par_odd  = pod;
    in_valid = 1'b1;
    step();                       // push edge
    in_valid = 1'b0;
    in_data  = ~d;
    total++;
    if ({fifo_level, tx, busy} !== 5'b001_10) begin
      bad++;
      $display("FAIL %s_after_push: level/tx/busy got %b want 00110", name, {fifo_level, tx, busy});
    end
    step();                       // pop edge, start bit begins
    par_odd = ~pod;
    total++;
    if ({fifo_level, busy} !== 4'b000_1) begin
      bad++;
      $display("FAIL %s_after_pop: level/busy got %b want 0001", name, {fifo_level, busy});
    end
    for (int i = 0; i < FL; i++) begin
      if (i > 0) step();
      total++;
      if ({tx, busy, done} !== {exp_bit(d, pexp, i / CPB), 2'b10}) begin
        bad++;
        $display("FAIL %s_bit cycle %0d: tx/busy/done got %b want %b",
                 name, i, {tx, busy, done}, {exp_bit(d, pexp, i / CPB), 2'b10});
      end
    end
    step();                       // end of stop bit
    total++;
    if ({tx, busy, done} !== 3'b101) begin
      bad++;
      $display("FAIL %s_done: tx/busy/done got %b want 101", name, {tx, busy, done});
    end
    step();
    total++;
    if ({tx, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL %s_after_done: tx/busy/done got %b want 100", name, {tx, busy, done});
    end
    par_odd = 1'b0;
  endtask

  // Five words pushed on consecutive edges, a sixth refused while full.
  task automatic test_back_to_back();
    logic [7:0] w [5];
    logic [2:0] lvl_exp [6];
    logic [7:0] cw;
    logic       etx;
    logic       ebusy;
    logic       edone;
    int         k;
    w[0] = 8'hA5; w[1] = 8'h5A; w[2] = 8'hFF; w[3] = 8'h00; w[4] = 8'h81;
    lvl_exp[0] = 3'd1; lvl_exp[1] = 3'd1; lvl_exp[2] = 3'd2;
    lvl_exp[3] = 3'd3; lvl_exp[4] = 3'd4; lvl_exp[5] = 3'd4;
    par_odd = 1'b0;
    do_reset();
    for (int t = 0; t <= 5 * FL + 3; t++) begin
      in_valid = (t <= 5);
      in_data  = (t < 5) ? w[t] : 8'hC3;
      step();
      if (t <= 5) begin
        total++;
        if ({fifo_level, in_ready} !== {lvl_exp[t], (t < 4)}) begin
          bad++;
          $display("FAIL b2b_level t=%0d: level/in_ready got %b want %b",
                   t, {fifo_level, in_ready}, {lvl_exp[t], (t < 4)});
        end
      end
      if (t >= 1 && t <= 5 * FL) begin
        k     = t - 1;
        cw    = w[k / FL];
        etx   = exp_bit(cw, ^cw, (k % FL) / CPB);
        ebusy = 1'b1;
      end else begin
        etx   = 1'b1;
        ebusy = 1'b0;
      end
      edone = (t > 1) && ((t - 1) % FL == 0) && (t <= 5 * FL + 1);
      total++;
      if ({tx, busy, done} !== {etx, ebusy, edone}) begin
        bad++;
        $display("FAIL b2b_line t=%0d: tx/busy/done got %b want %b",
                 t, {tx, busy, done}, {etx, ebusy, edone});
      end
    end
  endtask

  // Push held against a full FIFO while the head frame finishes.
  task automatic test_full_push_pop();
    do_reset();
    in_valid = 1'b1;
    for (int t = 0; t <= FL + 2; t++) begin
      in_data = 8'h10 + 8'(t);
      step();
      if (t >= 4 && t <= FL) begin
        total++;
        if ({fifo_level, in_ready} !== 4'b100_0) begin
          bad++;
          $display("FAIL full_hold t=%0d: level/in_ready got %b want 1000", t, {fifo_level, in_ready});
        end
      end
      if (t == FL + 1) begin
        total++;
        if ({fifo_level, in_ready, done, tx} !== 6'b011_1_1_0) begin
          bad++;
          $display("FAIL full_push_pop: level/in_ready/done/tx got %b want 011110",
                   {fifo_level, in_ready, done, tx});
        end
      end
      if (t == FL + 2) begin
        total++;
        if (fifo_level !== 3'd4) begin
          bad++;
          $display("FAIL full_refill: level got %0d want 4", fifo_level);
        end
      end
    end
    in_valid = 1'b0;
    do_reset();
  endtask

  // Two stop bits on the second instance: eight high cycles before done.
  task automatic test_two_stop();
    par_odd   = 1'b0;
    in_data2  = 8'h00;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    step();                       // pop edge
    for (int i = 0; i < NB2 * CPB; i++) begin
      if (i > 0) step();
      total++;
      if ({tx2, busy2, done2} !== {exp_bit(8'h00, 1'b0, i / CPB), 2'b10}) begin
        bad++;
        $display("FAIL two_stop cycle %0d: tx/busy/done got %b want %b",
                 i, {tx2, busy2, done2}, {exp_bit(8'h00, 1'b0, i / CPB), 2'b10});
      end
    end
    step();
    total++;
    if ({tx2, busy2, done2} !== 3'b101) begin
      bad++;
      $display("FAIL two_stop_done: tx/busy/done got %b want 101", {tx2, busy2, done2});
    end
  endtask

  // Reset in the middle of the data bits with two words queued.
  task automatic test_mid_reset();
    logic [7:0] w [3];
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'h96;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    total++;
    if ({busy, fifo_level} !== 4'b1_010) begin
      bad++;
      $display("FAIL mid_before: busy/level got %b want 1010", {busy, fifo_level});
    end
    rst_n = 1'b0;
    step();
    total++;
    if ({tx, busy, done, in_ready, fifo_level} !== 7'b1001_000) begin
      bad++;
      $display("FAIL mid_reset: tx/busy/done/in_ready/level got %b want 1001000",
               {tx, busy, done, in_ready, fifo_level});
    end
    rst_n = 1'b1;
    for (int i = 0; i < FL + 10; i++) begin
      step();
      total++;
      if ({tx, busy, done, fifo_level} !== 6'b100_000) begin
        bad++;
        $display("FAIL mid_after cycle %0d: tx/busy/done/level got %b want 100000",
                 i, {tx, busy, done, fifo_level});
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    par_odd   = 1'b0;
    in_data2  = 8'h00;
    in_valid2 = 1'b0;

    test_reset();
`ifdef UART_TX_PARITY_EN
    test_single_frame("par_a5_even", 8'hA5, 1'b0, 1'b0);
    test_single_frame("par_a5_odd",  8'hA5, 1'b1, 1'b1);
    test_single_frame("par_01_even", 8'h01, 1'b0, 1'b1);
`else
    test_single_frame("frame_a5", 8'hA5, 1'b0, 1'b0);
    test_single_frame("frame_3c", 8'h3C, 1'b1, 1'b0);
`endif
    test_back_to_back();
    test_full_push_pop();
    test_two_stop();
    test_mid_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
